// File: rtl/vx_fp_sqrt_iter.sv
// Iterative FP32 square root, LANES lock-step lanes, all RISC-V rounding modes; FPU_SQRT_SUBNORM_EN enables subnormal inputs (DAZ otherwise).
// Latency: accept in cycle 0, result valid in cycle 3+N (N = 26/RADIX_BITS); no overlap between operations.
// Backpressure: ready_in low from accept until the result handshake; result held stable while ready_out is low.
module vx_fp_sqrt_iter #(
    parameter int TAGW       = 1,
    parameter int LANES      = 1,
    parameter int RADIX_BITS = 1    // 1 or 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [TAGW-1:0]       tag_in,
    input  logic [2:0]            frm,
    input  logic [LANES*32-1:0]   dataa,
    output logic [LANES*32-1:0]   result,
    output logic                  has_fflags,
    output logic [LANES*5-1:0]    fflags,
    output logic [TAGW-1:0]       tag_out,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam int          N    = 26 / RADIX_BITS;
    localparam logic [4:0]  LAST = 5'(N - 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic [2:0]           r_frm;
    logic [TAGW-1:0]      r_tag;
    logic [LANES*32-1:0]  r_data;
    logic                 r_spec     [LANES];
    logic [31:0]          r_spec_res [LANES];
    logic                 r_spec_nv  [LANES];
    logic [7:0]           r_exp      [LANES];
    logic [51:0]          r_rad      [LANES];
    logic [29:0]          r_rem      [LANES];
    logic [25:0]          r_q        [LANES];

    logic                 w_spec     [LANES];
    logic [31:0]          w_spec_res [LANES];
    logic                 w_spec_nv  [LANES];
    logic [7:0]           w_exp_init [LANES];
    logic [51:0]          w_rad_init [LANES];
    logic [51:0]          w_rad_nxt  [LANES];
    logic [29:0]          w_rem_nxt  [LANES];
    logic [25:0]          w_q_nxt    [LANES];
    logic [LANES*32-1:0]  w_res;
    logic [LANES*5-1:0]   w_flg;

`ifdef FPU_SQRT_SUBNORM_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction
`endif

    // Classification and radicand set-up; an odd exponent is folded into the mantissa.
    always_comb begin
        logic              w_sgn;
        logic [7:0]        w_ex;
        logic [22:0]       w_fr;
        logic [23:0]       w_m24;
        logic [24:0]       w_m25;
        logic signed [9:0] w_e;
`ifdef FPU_SQRT_SUBNORM_EN
        logic [4:0]        w_lz;
`endif
        for (int l = 0; l < LANES; l++) begin
            w_sgn         = r_data[l*32+31];
            w_ex          = r_data[l*32+23 +: 8];
            w_fr          = r_data[l*32 +: 23];
            w_spec[l]     = 1'b0;
            w_spec_res[l] = 32'd0;
            w_spec_nv[l]  = 1'b0;
            w_m24         = {1'b1, w_fr};
            w_e           = $signed({2'b00, w_ex}) - 10'sd127;
            if (w_ex == 8'hFF) begin
                w_spec[l] = 1'b1;
                if (w_fr != 23'd0) begin
                    w_spec_res[l] = QNAN;
                    w_spec_nv[l]  = ~w_fr[22];
                end else if (w_sgn) begin
                    w_spec_res[l] = QNAN;
                    w_spec_nv[l]  = 1'b1;
                end else begin
                    w_spec_res[l] = 32'h7F80_0000;
                end
            end else if (w_ex == 8'h00) begin
`ifdef FPU_SQRT_SUBNORM_EN
                if (w_fr == 23'd0) begin
                    w_spec[l]     = 1'b1;
                    w_spec_res[l] = {w_sgn, 31'd0};
                end else if (w_sgn) begin
                    w_spec[l]     = 1'b1;
                    w_spec_res[l] = QNAN;
                    w_spec_nv[l]  = 1'b1;
                end else begin
                    w_lz  = lzc24({1'b0, w_fr});
                    w_m24 = {1'b0, w_fr} << w_lz;
                    w_e   = -10'sd126 - $signed({5'd0, w_lz});
                end
`else
                w_spec[l]     = 1'b1;
                w_spec_res[l] = {w_sgn, 31'd0};
`endif
            end else if (w_sgn) begin
                w_spec[l]     = 1'b1;
                w_spec_res[l] = QNAN;
                w_spec_nv[l]  = 1'b1;
            end
            if (w_e[0]) begin
                w_m25 = {w_m24, 1'b0};
                w_e   = w_e - 10'sd1;
            end else begin
                w_m25 = {1'b0, w_m24};
            end
            w_rad_init[l] = {w_m25, 27'd0};
            w_exp_init[l] = 8'(w_e >>> 1) + 8'd127;
        end
    end

    // Restoring recurrence: each step consumes two radicand bits and retires one root bit.
    always_comb begin
        logic [51:0] w_r;
        logic [29:0] w_m;
        logic [29:0] w_sh;
        logic [29:0] w_t;
        logic [25:0] w_qq;
        for (int l = 0; l < LANES; l++) begin
            w_r  = r_rad[l];
            w_m  = r_rem[l];
            w_qq = r_q[l];
            for (int s = 0; s < RADIX_BITS; s++) begin
                w_sh = {w_m[27:0], w_r[51:50]};
                w_t  = {2'b00, w_qq, 2'b01};
                if (w_sh >= w_t) begin
                    w_m  = w_sh - w_t;
                    w_qq = {w_qq[24:0], 1'b1};
                end else begin
                    w_m  = w_sh;
                    w_qq = {w_qq[24:0], 1'b0};
                end
                w_r = {w_r[49:0], 2'b00};
            end
            w_rad_nxt[l] = w_r;
            w_rem_nxt[l] = w_m;
            w_q_nxt[l]   = w_qq;
        end
    end

    // Root is always positive, so RDN truncates and RUP rounds away from zero.
    always_comb begin
        logic [23:0] w_mt;
        logic        w_g;
        logic        w_rb;
        logic        w_st;
        logic        w_nx;
        logic        w_inc;
        logic [24:0] w_sum;
        w_res = '0;
        w_flg = '0;
        for (int l = 0; l < LANES; l++) begin
            w_mt = r_q[l][25:2];
            w_g  = r_q[l][1];
            w_rb = r_q[l][0];
            w_st = |r_rem[l];
            w_nx = w_g | w_rb | w_st;
            case (r_frm)
                3'd1, 3'd2: w_inc = 1'b0;
                3'd3:       w_inc = w_nx;
                3'd4:       w_inc = w_g;
                default:    w_inc = w_g & (w_rb | w_st | w_mt[0]);
            endcase
            w_sum = {1'b0, w_mt} + {24'd0, w_inc};
            if (r_spec[l]) begin
                w_res[l*32 +: 32] = r_spec_res[l];
                w_flg[l*5 +: 5]   = {r_spec_nv[l], 4'b0000};
            end else begin
                if (w_sum[24])
                    w_res[l*32 +: 32] = {1'b0, r_exp[l] + 8'd1, w_sum[23:1]};
                else
                    w_res[l*32 +: 32] = {1'b0, r_exp[l], w_sum[22:0]};
                w_flg[l*5 +: 5] = {4'b0000, w_nx};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            ready_in   <= 1'b1;
            valid_out  <= 1'b0;
            has_fflags <= 1'b0;
            result     <= '0;
            fflags     <= '0;
            tag_out    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in && ready_in) begin
                        r_data   <= dataa;
                        r_frm    <= frm;
                        r_tag    <= tag_in;
                        ready_in <= 1'b0;
                        r_state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_spec[l]     <= w_spec[l];
                        r_spec_res[l] <= w_spec_res[l];
                        r_spec_nv[l]  <= w_spec_nv[l];
                        r_exp[l]      <= w_exp_init[l];
                        r_rad[l]      <= w_rad_init[l];
                        r_rem[l]      <= 30'd0;
                        r_q[l]        <= 26'd0;
                    end
                    r_cnt   <= 5'd0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_rad[l] <= w_rad_nxt[l];
                        r_rem[l] <= w_rem_nxt[l];
                        r_q[l]   <= w_q_nxt[l];
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST) r_state <= S_ROUND;
                end
                S_ROUND: begin
                    result     <= w_res;
                    fflags     <= w_flg;
                    tag_out    <= r_tag;
                    valid_out  <= 1'b1;
                    has_fflags <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (ready_out) begin
                        valid_out  <= 1'b0;
                        has_fflags <= 1'b0;
                        ready_in   <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_fp_sqrt_iter.sv
// Scoreboard bench for vx_fp_sqrt_iter with four lanes: directed operands, latency, hold and abort behaviour.
module tb_vx_fp_sqrt_iter;
    localparam int LANES = 4;
    localparam int TAGW  = 4;
    localparam int RB    = 1;
    localparam int LAT   = 26 / RB + 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                valid_in = 1'b0;
    logic                ready_in;
    logic [TAGW-1:0]     tag_in = '0;
    logic [2:0]          frm = 3'd0;
    logic [LANES*32-1:0] dataa = '0;
    logic [LANES*32-1:0] result;
    logic                has_fflags;
    logic [LANES*5-1:0]  fflags;
    logic [TAGW-1:0]     tag_out;
    logic                valid_out;
    logic                ready_out = 1'b1;

    vx_fp_sqrt_iter #(.TAGW(TAGW), .LANES(LANES), .RADIX_BITS(RB)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .tag_in(tag_in), .frm(frm), .dataa(dataa), .result(result),
        .has_fflags(has_fflags), .fflags(fflags), .tag_out(tag_out),
        .valid_out(valid_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [127:0]    res;
        logic [19:0]     flg;
        int              acc;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    logic [TAGW-1:0] tagc = '0;
    bit seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual result=%h required no output", result);
            end else begin
                if (!seen) begin
                    chk("latency", 128'(cyc - sb[0].acc), 128'(LAT));
                    seen = 1;
                end
                if (ready_out) begin
                    chk("result", result, sb[0].res);
                    chk("fflags", 128'(fflags), 128'(sb[0].flg));
                    chk("tag_out", 128'(tag_out), 128'(sb[0].tag));
                    chk("has_fflags", 128'(has_fflags), 128'd1);
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [2:0] rm,
                        input logic [127:0] er, input logic [19:0] ef, input bit push);
        bit ok;
        @(posedge clk); #1;
        valid_in = 1'b1;
        dataa    = d;
        frm      = rm;
        tag_in   = tagc;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_in) begin
                ok = 1;
                if (push) sb.push_back('{tag: tagc, res: er, flg: ef, acc: cyc});
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual ready_in=0 required 1");
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        tagc     = tagc + 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual pending=%0d required 0", sb.size());
            sb.delete();
            seen = 0;
        end
    endtask

    localparam logic [127:0] D_BASIC = {32'h3F800000, 32'h3E800000, 32'h41100000, 32'h40800000};
    localparam logic [127:0] R_BASIC = {32'h3F800000, 32'h3F000000, 32'h40400000, 32'h40000000};
    localparam logic [95:0]  FOURS_D = {32'h40800000, 32'h40800000, 32'h40800000};
    localparam logic [95:0]  FOURS_R = {32'h40000000, 32'h40000000, 32'h40000000};

    logic [31:0] r5 [5] = '{32'h400F1BBD, 32'h400F1BBC, 32'h400F1BBC, 32'h400F1BBD, 32'h400F1BBD};
    logic [2:0]  m2 [4] = '{3'd0, 3'd1, 3'd3, 3'd5};
    logic [31:0] r2 [4] = '{32'h3FB504F3, 32'h3FB504F3, 32'h3FB504F4, 32'h3FB504F3};

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r7;
        logic [19:0]  f7;
        bit           got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 128'(valid_out), 128'd0);
        chk("rst_ready_in", 128'(ready_in), 128'd1);
        chk("rst_has_fflags", 128'(has_fflags), 128'd0);
        chk("rst_result", result, 128'd0);
        chk("rst_fflags", 128'(fflags), 128'd0);
        chk("rst_tag_out", 128'(tag_out), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        send(D_BASIC, 3'd0, R_BASIC, 20'h00000, 1);
        drain();

        for (int i = 0; i < 4; i++) begin
            send({FOURS_D, 32'h40000000}, m2[i], {FOURS_R, r2[i]}, 20'h00001, 1);
            drain();
        end

        for (int i = 0; i < 5; i++) begin
            send({4{32'h40A00000}}, 3'(i), {4{r5[i]}}, 20'h08421, 1);
            drain();
        end

        send({32'h7F800001, 32'h7F800000, 32'h80000000, 32'hBF800000}, 3'd0,
             {32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000}, 20'h80010, 1);
        drain();

`ifdef FPU_SQRT_SUBNORM_EN
        r7 = {32'h00000000, 32'h7FC00000, 32'h1A3504F3, 32'h7FC00000};
        f7 = 20'h04020;
`else
        r7 = {32'h00000000, 32'h7FC00000, 32'h00000000, 32'h7FC00000};
        f7 = 20'h04000;
`endif
        send({32'h00000000, 32'hFF800000, 32'h00000001, 32'h7FC00000}, 3'd0, r7, f7, 1);
        drain();

        send({32'h7F800000, 32'h40000000, 32'hBF800000, 32'h40800000}, 3'd0,
             {32'h7F800000, 32'h3FB504F3, 32'h7FC00000, 32'h40000000}, 20'h00600, 1);
        drain();

        ready_out = 1'b0;
        send({FOURS_D, 32'h40A00000}, 3'd3, {FOURS_R, 32'h400F1BBD}, 20'h00001, 1);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_out) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL hold_wait: actual valid_out=0 required 1");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_result", result, {FOURS_R, 32'h400F1BBD});
            chk("hold_ready_in", 128'(ready_in), 128'd0);
            chk("hold_valid_out", 128'(valid_out), 128'd1);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        drain();

        send(D_BASIC, 3'd0, R_BASIC, 20'h00000, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_ready_in", 128'(ready_in), 128'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid_out", 128'(valid_out), 128'd0);
        chk("abort_ready_in", 128'(ready_in), 128'd1);
        repeat (40) @(negedge clk);

        send(D_BASIC, 3'd4, R_BASIC, 20'h00000, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
